// File: rtl/latch_write_arbiter.sv
// Round-robin owner of a shared gated-latch bank. Each write is sequenced as
// setup -> enable pulse -> hold so latch D is stable around every En pulse.
module latch_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int NUM_LATCH = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ*AW-1:0]    req_addr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic                   busy,
  output logic [WIDTH-1:0]       latch_d,
  output logic [NUM_LATCH-1:0]   latch_en
);

  localparam int MAX_CYC = (SETUP_CYC > EN_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d, win_q, win_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d, ack_q, ack_d;
  logic                 err_q, err_d, busy_q, busy_d;
  logic [NUM_LATCH-1:0] en_q, en_d;

  logic                 found_s, hit_s, owned_s, in_range_s;
  logic [PW-1:0]        idx_s, sel_s;
  logic [AW-1:0]        addr_sel_s;
  logic [WIDTH-1:0]     data_sel_s;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end else begin
      s = s;
    end
    return PW'(s);
  endfunction

  // Round-robin search from the pointer, then pick the winner's data/address.
  always_comb begin
    found_s    = 1'b0;
    hit_s      = 1'b0;
    idx_s      = ptr_q;
    sel_s      = ptr_q;
    data_sel_s = {WIDTH{1'b0}};
    addr_sel_s = {AW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      idx_s   = wrap_idx(ptr_q, i);
      hit_s   = !found_s && req[idx_s];
      sel_s   = hit_s ? idx_s : sel_s;
      found_s = found_s | hit_s;
    end
    for (int i = 0; i < N_REQ; i++) begin
      data_sel_s = (sel_s == PW'(i)) ? req_data[i*WIDTH +: WIDTH] : data_sel_s;
      addr_sel_s = (sel_s == PW'(i)) ? req_addr[i*AW +: AW] : addr_sel_s;
    end
  end

  // Transaction sequencer; the counter reloads on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          ptr_d   = (int'(sel_s) == N_REQ - 1) ? {PW{1'b0}} : sel_s + PW'(1);
          win_d   = sel_s;
          addr_d  = addr_sel_s;
          data_d  = data_sel_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_ENABLE;
          cnt_d   = CW'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ENABLE: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_DONE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    owned_s    = state_d inside {S_SETUP, S_ENABLE, S_HOLD};
    in_range_s = (int'(addr_d) < NUM_LATCH);
    gnt_d      = {N_REQ{1'b0}};
    ack_d      = {N_REQ{1'b0}};
    en_d       = {NUM_LATCH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      gnt_d[i] = owned_s && (win_d == PW'(i));
      ack_d[i] = (state_d == S_DONE) && (win_d == PW'(i));
    end
    for (int j = 0; j < NUM_LATCH; j++) begin
      en_d[j] = (state_d == S_ENABLE) && (int'(addr_d) == j);
    end
    err_d  = (state_d == S_DONE) && !in_range_s;
    busy_d = (state_d != S_IDLE);
  end

  // State, captured request and all outputs share one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      ptr_q   <= {PW{1'b0}};
      win_q   <= {PW{1'b0}};
      addr_q  <= {AW{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      gnt_q   <= {N_REQ{1'b0}};
      ack_q   <= {N_REQ{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= {NUM_LATCH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign latch_d  = data_q;
  assign latch_en = en_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed literal scenarios plus randomized traffic
// checked every cycle against a transaction-timeline model (4- and 3-latch banks).
module tb_latch_write_arbiter;
  localparam int N = 4, W = 8, AW = 2, S = 1, E = 2, H = 1, L = S + E + H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]   gnt, ack, gnt_b, ack_b;
  logic           err, busy, err_b, busy_b;
  logic [W-1:0]   latch_d, latch_d_b;
  logic [3:0]     latch_en;
  logic [2:0]     latch_en_b;
  int errors = 0;
  int checks = 0;

  // Model: m_t = cycles since grant edge, -1 when idle.
  int m_t, m_ptr, m_own, m_addr;
  logic [W-1:0] m_d;

  always #5 clk = ~clk;

  latch_write_arbiter #(.N_REQ(4), .WIDTH(8), .NUM_LATCH(4), .AW(2),
                        .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_addr(req_addr),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy), .latch_d(latch_d), .latch_en(latch_en));

  latch_write_arbiter #(.N_REQ(4), .WIDTH(8), .NUM_LATCH(3), .AW(2),
                        .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_addr(req_addr),
    .gnt(gnt_b), .ack(ack_b), .err(err_b), .busy(busy_b), .latch_d(latch_d_b),
    .latch_en(latch_en_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = -1; m_ptr = 0; m_own = 0; m_addr = 0; m_d = '0;
  endtask

  task automatic model_step();
    if (m_t < 0) begin
      int win = -1;
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (win < 0 && req[c]) win = c;
      end
      if (win >= 0) begin
        m_own  = win;
        m_d    = req_data[win*W +: W];
        m_addr = int'(req_addr[win*AW +: AW]);
        m_ptr  = (win + 1) % N;
        m_t    = 0;
      end
    end else if (m_t == L) begin
      m_t = -1;
    end else begin
      m_t++;
    end
  endtask

  task automatic model_compare();
    logic [3:0] eg, ea, ee4;
    logic [2:0] ee3;
    logic       done;
    eg = '0; ea = '0; ee4 = '0; ee3 = '0;
    done = (m_t == L);
    if (m_t >= 0 && m_t < L) eg[m_own] = 1'b1;
    if (done) ea[m_own] = 1'b1;
    if (m_t >= S && m_t < S + E) begin
      if (m_addr < 4) ee4[m_addr] = 1'b1;
      if (m_addr < 3) ee3[m_addr] = 1'b1;
    end
    check("m_gnt",   32'(gnt),      32'(eg));
    check("m_ack",   32'(ack),      32'(ea));
    check("m_err",   32'(err),      32'(done && m_addr >= 4));
    check("m_busy",  32'(busy),     32'(m_t >= 0));
    check("m_d",     32'(latch_d),  32'(m_d));
    check("m_en",    32'(latch_en), 32'(ee4));
    check("m3_gnt",  32'(gnt_b),    32'(eg));
    check("m3_ack",  32'(ack_b),    32'(ea));
    check("m3_err",  32'(err_b),    32'(done && m_addr >= 3));
    check("m3_busy", 32'(busy_b),   32'(m_t >= 0));
    check("m3_d",    32'(latch_d_b), 32'(m_d));
    check("m3_en",   32'(latch_en_b), 32'(ee3));
  endtask

  // Monitor: advance the model on each rising edge, compare on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      if (!rst_n) model_reset();
      model_compare();
    end
  end

  task automatic tick();
    @(negedge clk);
    req = req & ~ack;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [AW-1:0] a);
    req[i] = 1'b1;
    req_data[i*W +: W] = d;
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 20) begin
      tick();
      c++;
    end
    check({name, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic expect_grant(input string name, input int exp);
    int who = -1;
    for (int c = 0; c < 20 && who < 0; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (gnt[i]) who = i;
    end
    check(name, who, exp);
  endtask

  initial begin
    req = '0; req_data = '0; req_addr = '0;
    do_reset();
    check("rst_gnt",  32'(gnt),      32'h0);
    check("rst_ack",  32'(ack),      32'h0);
    check("rst_err",  32'(err),      32'h0);
    check("rst_busy", 32'(busy),     32'h0);
    check("rst_d",    32'(latch_d),  32'h0);
    check("rst_en",   32'(latch_en), 32'h0);

    // Basic write: A5 to latch 2.
    set_req(0, 8'hA5, 2'd2);
    tick(); check("t1_gnt", 32'(gnt), 32'h1); check("t1_d", 32'(latch_d), 32'hA5);
            check("t1_en_setup", 32'(latch_en), 32'h0);
    tick(); check("t1_en1", 32'(latch_en), 32'h4);
    tick(); check("t1_en2", 32'(latch_en), 32'h4);
    tick(); check("t1_en_hold", 32'(latch_en), 32'h0); check("t1_gnt_hold", 32'(gnt), 32'h1);
    tick(); check("t1_ack", 32'(ack), 32'h1); check("t1_err", 32'(err), 32'h0);
            check("t1_gnt_done", 32'(gnt), 32'h0);
    wait_idle("t1");

    // Inputs changed during SETUP are ignored.
    set_req(0, 8'h3C, 2'd1);
    tick(); check("t5_d0", 32'(latch_d), 32'h3C);
    req_data[7:0] = 8'hFF; req_addr[1:0] = 2'd3;
    tick(); check("t5_d1", 32'(latch_d), 32'h3C); check("t5_en1", 32'(latch_en), 32'h2);
    tick(); check("t5_d2", 32'(latch_d), 32'h3C); check("t5_en2", 32'(latch_en), 32'h2);
    tick(); check("t5_en_hold", 32'(latch_en), 32'h0);
    tick(); check("t5_ack", 32'(ack), 32'h1);
    wait_idle("t5");

    // Out-of-range address on the 3-latch bank.
    set_req(0, 8'h5A, 2'd3);
    for (int k = 0; k < L; k++) begin
      tick(); check("t6_en3", 32'(latch_en_b), 32'h0);
    end
    tick(); check("t6_ack3", 32'(ack_b), 32'h1); check("t6_err3", 32'(err_b), 32'h1);
            check("t6_err4", 32'(err), 32'h0); check("t6_en3_done", 32'(latch_en_b), 32'h0);
    wait_idle("t6");

    // All four request together, then 0 and 2 again.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 2'(i));
    for (int k = 0; k < N; k++) begin
      expect_grant("t2_order", k);
      wait_idle("t2");
    end
    set_req(0, 8'h21, 2'd1); set_req(2, 8'h22, 2'd2);
    expect_grant("t2_re0", 0); wait_idle("t2r");
    expect_grant("t2_re2", 2); wait_idle("t2r");

    // Pointer after serving requester 1 favours 3 over 1.
    do_reset();
    set_req(1, 8'h31, 2'd0);
    expect_grant("t3_first", 1); wait_idle("t3");
    set_req(1, 8'h32, 2'd1); set_req(3, 8'h33, 2'd3);
    expect_grant("t3_a", 3); wait_idle("t3");
    expect_grant("t3_b", 1); wait_idle("t3");

    // Asynchronous reset mid-ENABLE.
    do_reset();
    set_req(0, 8'h77, 2'd0);
    tick(); check("t4_gnt", 32'(gnt), 32'h1);
    tick(); check("t4_en", 32'(latch_en), 32'h1);
    #1 rst_n = 1'b0;
    #1 check("t4_rst_en", 32'(latch_en), 32'h0); check("t4_rst_gnt", 32'(gnt), 32'h0);
       check("t4_rst_busy", 32'(busy), 32'h0);
    set_req(1, 8'h78, 2'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    expect_grant("t4_after", 0); wait_idle("t4");
    expect_grant("t4_next", 1); wait_idle("t4");

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        req_data[i*W +: W] = 8'($urandom);
        req_addr[i*AW +: AW] = 2'($urandom);
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) req = req & ~gnt;
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    req = '0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
